// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: bus FSM encoding and default parameters for stream_apb_bridge
package apb_bridge_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } state_t;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_ADDR_W      = 5;
    localparam int DEF_WFIFO_DEPTH = 4;
    localparam int DEF_TIMEOUT     = 15;
endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: power-of-two FIFO with combinational head; push accepted when full only alongside a pop
module stream_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] count;
    logic do_push, do_pop;
    always_comb begin
        full    = count == (AW+1)'(DEPTH);
        empty   = count == '0;
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        head    = mem[rd_ptr];
    end
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/stream_apb_bridge.sv
// stream_apb_bridge: stream-to-APB requester; FIFO-buffered writes, reads returned on a stream, timeout abort
module stream_apb_bridge
    import apb_bridge_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WFIFO_DEPTH = DEF_WFIFO_DEPTH,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_err,
    input  logic [ADDR_W-1:0] base_address,
    input  logic              latch_address,
    input  logic              auto_inc,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    output logic              err_sticky,
    output logic              timeout_sticky,
    input  logic              clear_err
);
    state_t state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [7:0] wait_cnt;
    logic [DATA_W-1:0] head;
    logic wr_flag, start, complete, abort, done, full, empty;

    stream_fifo #(.DATA_W(DATA_W), .DEPTH(WFIFO_DEPTH)) u_fifo (
        .CLK(CLK),
        .RESETn(RESETn),
        .push(in_valid && !full),
        .push_data(in_data),
        .pop(done && wr_flag),
        .head(head),
        .full(full),
        .empty(empty)
    );

    always_comb begin
        start     = (state == IDLE) && !latch_address && (!empty || (out_ready && !out_valid));
        complete  = (state == ACCESS) && PREADY;
        abort     = (state == ACCESS) && !PREADY && (wait_cnt == 8'(TIMEOUT - 1));
        done      = complete || abort;
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        in_ready = !full;
        PSEL     = state != IDLE;
        PENABLE  = state == ACCESS;
        PWRITE   = PSEL && wr_flag;
        PADDR    = addr;
        PWDATA   = head;
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state          <= IDLE;
            addr           <= '0;
            wr_flag        <= 1'b0;
            wait_cnt       <= '0;
            out_data       <= '0;
            out_valid      <= 1'b0;
            out_err        <= 1'b0;
            err_sticky     <= 1'b0;
            timeout_sticky <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == ACCESS) ? wait_cnt + 8'd1 : '0;
            if (start) wr_flag <= !empty;
            if ((state == IDLE) && latch_address) addr <= base_address;
            else if (done && auto_inc) addr <= addr + ADDR_W'(1);
            if (done && !wr_flag) begin
                out_data  <= complete ? PRDATA : '0;
                out_valid <= 1'b1;
                out_err   <= abort || PSLVERR;
            end else if (out_valid && out_ready) begin
                out_data  <= '0;
                out_valid <= 1'b0;
                out_err   <= 1'b0;
            end
            err_sticky     <= clear_err ? 1'b0 : (err_sticky || (complete && PSLVERR));
            timeout_sticky <= clear_err ? 1'b0 : (timeout_sticky || abort);
        end
    end
endmodule

// File: tb/tb_stream_apb_bridge.sv
// tb_stream_apb_bridge: directed and random stimulus against a transfer-level reference model
module tb_stream_apb_bridge;
    localparam int DW = 8, AW = 5, DEPTH = 4, TO = 15;
    logic CLK = 1'b0, RESETn = 1'b0;
    logic [DW-1:0] in_data = '0, out_data, PWDATA, PRDATA = '0;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_err;
    logic [AW-1:0] base_address = '0, PADDR;
    logic latch_address = 1'b0, auto_inc = 1'b0, PSEL, PENABLE, PWRITE;
    logic PREADY = 1'b0, PSLVERR = 1'b0, err_sticky, timeout_sticky, clear_err = 1'b0;
    int n_cmp = 0, n_bad = 0;
    logic [DW-1:0] q[$];
    int mph = 0, acc = 0;
    bit cur_wr = 0, stall = 0, m_ov = 0, m_oe = 0, m_es = 0, m_ts = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_od = '0;

    stream_apb_bridge #(.DATA_W(DW), .ADDR_W(AW), .WFIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_err(out_err),
        .base_address(base_address), .latch_address(latch_address), .auto_inc(auto_inc),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .err_sticky(err_sticky), .timeout_sticky(timeout_sticky), .clear_err(clear_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task model_step();
        bit was_full, old_ov, cpl, abt;
        if (!RESETn) begin
            q.delete();
            mph = 0; acc = 0; m_addr = '0; m_od = '0;
            m_ov = 0; m_oe = 0; m_es = 0; m_ts = 0;
            return;
        end
        was_full = q.size() == DEPTH;
        old_ov = m_ov;
        cpl = 0;
        abt = 0;
        if (m_ov && out_ready) begin
            m_ov = 0; m_od = '0; m_oe = 0;
        end
        if (mph == 0) begin
            if (latch_address) m_addr = base_address;
            else if (q.size() > 0 || (out_ready && !old_ov)) begin
                cur_wr = q.size() > 0;
                mph = 1;
            end
        end else if (mph == 1) begin
            mph = 2;
            acc = 0;
        end else begin
            acc++;
            cpl = PREADY;
            abt = !PREADY && acc == TO;
            if (cpl || abt) begin
                mph = 0;
                if (cur_wr) void'(q.pop_front());
                else begin
                    m_od = cpl ? PRDATA : '0;
                    m_ov = 1;
                    m_oe = abt || PSLVERR;
                end
                if (auto_inc) m_addr++;
                if (cpl && PSLVERR) m_es = 1;
                if (abt) m_ts = 1;
            end
        end
        if (clear_err) begin
            m_es = 0; m_ts = 0;
        end
        if (in_valid && !was_full) q.push_back(in_data);
    endtask

    task compare();
        chk("psel", PSEL, mph != 0);
        chk("penable", PENABLE, mph == 2);
        chk("pwrite", PWRITE, mph != 0 && cur_wr);
        chk("paddr", PADDR, m_addr);
        if (mph != 0 && cur_wr) chk("pwdata", PWDATA, q[0]);
        chk("in_ready", in_ready, q.size() < DEPTH);
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_od);
        chk("out_err", out_err, m_oe);
        chk("err_sticky", err_sticky, m_es);
        chk("timeout_sticky", timeout_sticky, m_ts);
    endtask

    task tick();
        model_step();
        @(posedge CLK);
        @(negedge CLK);
        compare();
    endtask

    task quiesce();
        in_valid = 0; out_ready = 0; PREADY = 1; latch_address = 0; clear_err = 0; PSLVERR = 0;
        for (int i = 0; i < 100 && !(mph == 0 && q.size() == 0); i++) tick();
        if (!(mph == 0 && q.size() == 0)) chk("quiesce_bound", 0, 1);
        if (m_ov) begin
            out_ready = 1;
            tick();
            out_ready = 0;
        end
    endtask

    task wait_ov(input int max);
        for (int i = 0; i < max && !m_ov; i++) tick();
        if (!m_ov) chk("wait_ov_bound", 0, 1);
    endtask

    initial begin
        RESETn = 0;
        tick();
        tick();
        RESETn = 1;
        // writes across the address wrap
        auto_inc = 1; PREADY = 1;
        latch_address = 1; base_address = 5'h1E;
        tick();
        latch_address = 0;
        in_valid = 1;
        in_data = 8'hA1; tick();
        in_data = 8'hA2; tick();
        in_data = 8'hA3; tick();
        in_valid = 0;
        repeat (12) tick();
        chk("wrap_addr", PADDR, 5'h01);
        // read with three wait states
        quiesce();
        out_ready = 1; PRDATA = 8'h5A;
        for (int i = 0; i < 20 && !m_ov; i++) begin
            PREADY = (mph == 2 && acc == 3);
            tick();
        end
        if (!m_ov) chk("read_wait_bound", 0, 1);
        chk("read_data", out_data, 8'h5A);
        chk("read_err", out_err, 0);
        out_ready = 0;
        // FIFO fill and write timeout
        quiesce();
        PREADY = 0; in_valid = 1;
        for (int i = 0; i < 6; i++) begin
            in_data = 8'($urandom);
            tick();
        end
        chk("fifo_full", in_ready, 0);
        in_valid = 0;
        repeat (16) tick();
        chk("timeout_flag", timeout_sticky, 1);
        clear_err = 1; PREADY = 1;
        tick();
        clear_err = 0;
        quiesce();
        // slave error on read, then clear against a simultaneous new error
        out_ready = 1; PSLVERR = 1;
        wait_ov(10);
        chk("slverr_out", out_err, 1);
        chk("slverr_sticky", err_sticky, 1);
        tick();
        for (int i = 0; i < 10 && !m_ov; i++) begin
            clear_err = (mph == 2);
            tick();
        end
        clear_err = 0;
        chk("clear_wins", err_sticky, 0);
        quiesce();
        // fixed-address reads
        auto_inc = 0; latch_address = 1; base_address = 5'h07;
        tick();
        latch_address = 0; out_ready = 1; PRDATA = 8'h33;
        repeat (12) tick();
        chk("fixed_addr", PADDR, 5'h07);
        quiesce();
        // reset in the middle of ACCESS
        auto_inc = 1; out_ready = 1; PREADY = 0;
        for (int i = 0; i < 10 && mph != 2; i++) tick();
        if (mph != 2) chk("access_bound", 0, 1);
        tick();
        RESETn = 0;
        tick();
        RESETn = 1;
        chk("rst_psel", PSEL, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_out_valid", out_valid, 0);
        out_ready = 0;
        // random traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid = $urandom_range(0, 1);
            in_data = 8'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            latch_address = $urandom_range(0, 15) == 0;
            base_address = 5'($urandom);
            auto_inc = $urandom_range(0, 3) != 0;
            clear_err = $urandom_range(0, 31) == 0;
            PRDATA = 8'($urandom);
            PSLVERR = $urandom_range(0, 7) == 0;
            if (mph == 1) stall = $urandom_range(0, 9) == 0;
            PREADY = !stall && $urandom_range(0, 2) != 0;
            tick();
        end
        quiesce();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/stream_apb_bridge.md
STREAM_APB_BRIDGE -- requirements
Module: stream_apb_bridge

Interface
REQ-001 Parameter DATA_W, default 8, width of stream data and PWDATA/PRDATA.
REQ-002 Parameter ADDR_W, default 5, width of PADDR and base_address.
REQ-003 Parameter WFIFO_DEPTH, default 4, write-data FIFO entries, power of two, at least 2.
REQ-004 Parameter TIMEOUT, default 15, maximum ACCESS cycles before abort, range 1..255.
REQ-005 CLK input 1: the single clock; all state updates on its rising edge.
REQ-006 RESETn input 1: reset, synchronous and active-low.
REQ-007 in_data/in_valid/in_ready input DATA_W / input 1 / output 1: write stream.
REQ-008 out_data/out_valid/out_ready/out_err output DATA_W / output 1 / input 1 / output 1: read stream; out_err flags a failed read.
REQ-009 base_address/latch_address/auto_inc input ADDR_W / input 1 / input 1: address load and increment enable.
REQ-010 PSEL, PENABLE, PWRITE output 1; PADDR output ADDR_W; PWDATA output DATA_W; PRDATA input DATA_W; PREADY, PSLVERR input 1: APB requester.
REQ-011 err_sticky output 1 (PSLVERR seen); timeout_sticky output 1; clear_err input 1 clears both.

Function
REQ-012 Write FIFO: in_ready = not full; push on in_valid & in_ready; pop at completion of a write transfer; push and pop in the same cycle are allowed when full.
REQ-013 Bus FSM states IDLE, SETUP, ACCESS. IDLE->SETUP on start; SETUP->ACCESS always; ACCESS->IDLE on PREADY or timeout.
REQ-014 Start in IDLE when latch_address=0 and either FIFO non-empty (write) or out_ready & ~out_valid (read); write has priority.
REQ-015 latch_address in IDLE loads base_address and suppresses start that cycle; ignored outside IDLE.
REQ-016 PSEL = state!=IDLE; PENABLE = state==ACCESS; PWRITE = write flag when PSEL, else 0; PADDR = current address register.
REQ-017 PWDATA = FIFO head, held stable from SETUP through completion.
REQ-018 Completion: ACCESS & PREADY. Address increments by 1 modulo 2^ADDR_W at completion or abort iff auto_inc=1 (sampled at completion).
REQ-019 A read completion loads out_data=PRDATA, out_valid=1, out_err=PSLVERR; a read abort loads out_data=0, out_valid=1, out_err=1.
REQ-020 out_valid clears on out_valid & out_ready; out_data and out_err clear to 0 at the same time.
REQ-021 Wait counter reset on entry to ACCESS; abort when the counter reaches TIMEOUT without PREADY. An aborted write still pops its FIFO entry.
REQ-022 PSLVERR sampled only at completion; sets err_sticky. Abort sets timeout_sticky. clear_err has priority over a simultaneous set.
REQ-023 Latency: the first PSEL occurs 1 cycle after the start condition; a zero-wait-state transfer lasts 2 cycles, followed by at least 1 IDLE cycle.

Reset
REQ-024 On RESETn=0 at a clock edge: state IDLE, address 0, FIFO empty, wait counter 0, every output register and sticky flag 0, and in_ready=1 from the next cycle.
REQ-025 Reset mid-transfer drops the transfer immediately, with no address increment and no output.

Structure
REQ-026 Package apb_bridge_pkg holds the FSM state encoding (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10) and the default parameter constants.
REQ-027 Sub-module stream_fifo (parametrised DATA_W, DEPTH; push/pop/full/empty) implements the write FIFO.

Verification
REQ-028 latch 5'h1E, auto_inc=1, push A1,A2,A3 with PREADY=1 -> writes to PADDR 1E,1F,00, each 2 cycles, with IDLE between.
REQ-029 out_ready=1, no input, PRDATA=5A, PREADY delayed 3 cycles -> out_data=5A, out_valid=1, out_err=0, PADDR held through wait states.
REQ-030 Push 6 words, depth 4, PREADY=0 -> in_ready=0 after 4; TIMEOUT=15 abort after 15 ACCESS cycles, timeout_sticky=1, FIFO pops one.
REQ-031 Read with PSLVERR=1 -> out_err=1, err_sticky=1; clear_err with a simultaneous new error -> err_sticky=0.
REQ-032 auto_inc=0, three reads at address 07 -> all on PADDR 07.
REQ-033 RESETn=0 during ACCESS -> PSEL=0 next cycle, address 0, out_valid=0.
